// File: rtl/pktctrl_pkg.sv
// Shared types for the packet-control subsystem: word widths, the buffered
// entry layout and the write-side FSM states of the transmit buffer.
package pktctrl_pkg;

    localparam int unsigned PKT_IN_W  = 96;
    localparam int unsigned PKT_OUT_W = 32;

    // One buffered packet word with its framing flags.
    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [PKT_IN_W-1:0] data;
    } pkt_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } wr_state_e;

endpackage

// File: rtl/pkt_tx_ser.sv
// Output holding register and beat serializer. Splits one buffered entry
// into PKT_IN_W/OUT_W beats, LSB slice first, on a valid/ready stream.
// Ports:
//   load_valid_i/load_entry_i : committed entry available from the buffer
//   load_ready_c              : entry is taken this cycle when load_valid_i is high
//   out_ready_i               : consumer accepts the current beat
//   out_valid_o/out_data_o/out_sop_o/out_eop_o : registered beat stream
module pkt_tx_ser
    import pktctrl_pkg::*;
#(
    parameter int unsigned OUT_W = PKT_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid_i,
    input  pkt_entry_t       load_entry_i,
    output logic             load_ready_c,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_sop_o,
    output logic             out_eop_o
);

    localparam int unsigned RATIO  = PKT_IN_W / OUT_W;
    localparam int unsigned REST_W = PKT_IN_W - OUT_W;
    localparam int unsigned BW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    logic [REST_W-1:0] rest_q;
    logic              hold_eop_q;
    logic [BW-1:0]     beat_q;
    logic              valid_q;
    logic [OUT_W-1:0]  data_q;
    logic              sop_q;
    logic              eop_q;

    logic              fire;
    logic              last_beat;
    logic              load;
    logic [BW-1:0]     beat_nxt;

    assign fire      = valid_q & out_ready_i;
    assign last_beat = (beat_q == LAST_BEAT);
    // Reload on the same edge the final beat leaves, so packets flow without a bubble.
    assign load_ready_c = ~valid_q | (fire & last_beat);
    assign load      = load_valid_i & load_ready_c;
    assign beat_nxt  = beat_q + BW'(1);

    // Remaining slices sit in a shift register; beat 0 goes straight to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rest_q     <= '0;
            hold_eop_q <= 1'b0;
            beat_q     <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
        end else if (load) begin
            rest_q     <= load_entry_i.data[PKT_IN_W-1:OUT_W];
            hold_eop_q <= load_entry_i.eop;
            beat_q     <= '0;
            valid_q    <= 1'b1;
            data_q     <= load_entry_i.data[OUT_W-1:0];
            sop_q      <= load_entry_i.sop;
            eop_q      <= 1'b0;
        end else if (fire) begin
            if (last_beat) begin
                beat_q  <= '0;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
            end else begin
                beat_q  <= beat_nxt;
                data_q  <= rest_q[OUT_W-1:0];
                rest_q  <= rest_q >> OUT_W;
                sop_q   <= 1'b0;
                eop_q   <= hold_eop_q & (beat_nxt == LAST_BEAT);
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_sop_o   = sop_q;
    assign out_eop_o   = eop_q;

endmodule

// File: rtl/pkt_tx_buf.sv
// Store-and-forward packet buffer with 96->32 width conversion. Accepts
// unstallable packet words, releases only committed packets, and drops whole
// packets that overflow or are cut short by a new sop.
// Ports:
//   in_valid/in_data/in_sop/in_eop : input word stream, no backpressure
//   out_valid/out_ready/out_data/out_sop/out_eop : serialized output stream
//   fifo_level : occupied entries including the packet being received
//   drop_cnt   : saturating count of dropped packets
//   ovf_pulse  : one-cycle pulse per drop event
module pkt_tx_buf
    import pktctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IN_W  = PKT_IN_W,
    parameter int unsigned OUT_W = PKT_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_sop,
    input  logic                     in_eop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_cnt,
    output logic                     ovf_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    pkt_entry_t     mem_q [DEPTH];
    wr_state_e      state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  level_q;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           ovf_q;

    logic           we;
    logic [PW-1:0]  wr_addr;
    logic [1:0]     drops;
    logic [16:0]    drop_sum;
    logic           full_wr, full_base;
    logic           rd_avail, ser_ready_c, ser_load;
    pkt_entry_t     wr_entry;

    // full_base covers a new packet starting at the committed boundary.
    assign full_wr   = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign full_base = ((commit_ptr_q - rd_ptr_q) == PW'(DEPTH));
    assign wr_entry  = '{sop: in_sop, eop: in_eop, data: PKT_IN_W'(in_data)};

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Write FSM next state.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (in_sop) begin
                if (in_eop)         state_d = IDLE;
                else if (full_base) state_d = DISCARD;
                else                state_d = RECV;
            end else if (state_q == RECV) begin
                if (in_eop)         state_d = IDLE;
                else if (full_wr)   state_d = DISCARD;
            end else if ((state_q == DISCARD) && in_eop) begin
                state_d = IDLE;
            end
        end
    end

    // Write FSM outputs: memory write, pointer updates and drop events.
    // A sop always restarts at commit_ptr, which also discards any partial packet.
    always_comb begin
        we           = 1'b0;
        wr_addr      = wr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drops        = 2'd0;
        if (in_valid) begin
            if (in_sop) begin
                if (state_q == RECV) drops = 2'd1;
                if (full_base) begin
                    drops    = drops + 2'd1;
                    wr_ptr_d = commit_ptr_q;
                end else begin
                    we       = 1'b1;
                    wr_addr  = commit_ptr_q;
                    wr_ptr_d = commit_ptr_q + PW'(1);
                    if (in_eop) commit_ptr_d = commit_ptr_q + PW'(1);
                end
            end else if (state_q == RECV) begin
                if (full_wr) begin
                    drops    = 2'd1;
                    wr_ptr_d = commit_ptr_q;
                end else begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (in_eop) commit_ptr_d = wr_ptr_q + PW'(1);
                end
            end
        end
    end

    assign drop_sum   = {1'b0, drop_cnt_q} + 17'(drops);
    assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // Read side only ever sees committed entries.
    assign rd_avail = (rd_ptr_q != commit_ptr_q);
    assign ser_load = rd_avail & ser_ready_c;
    assign rd_ptr_d = ser_load ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            drop_cnt_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= wr_ptr_d - rd_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            ovf_q        <= (drops != 2'd0);
        end
    end

    // Packet storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr[AW-1:0]] <= wr_entry;
    end

    pkt_tx_ser #(
        .OUT_W (OUT_W)
    ) u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (rd_avail),
        .load_entry_i (mem_q[rd_ptr_q[AW-1:0]]),
        .load_ready_c (ser_ready_c),
        .out_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_sop_o    (out_sop),
        .out_eop_o    (out_eop)
    );

    assign fifo_level = level_q;
    assign drop_cnt   = drop_cnt_q;
    assign ovf_pulse  = ovf_q;

endmodule
